// File: rtl/ctrlport_req_arbiter_pkg.sv
// rtl/ctrlport_req_arbiter_pkg.sv - shared constants and types for the ControlPort request arbiter
package ctrlport_req_arbiter_pkg;

    localparam logic [1:0] CTRL_STS_OKAY   = 2'b00;
    localparam logic [1:0] CTRL_STS_CMDERR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // A single-port build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrlport_rr_select.sv
// rtl/ctrlport_rr_select.sv - combinational round-robin pick of the next pending port after last_grant
module ctrlport_rr_select
    import ctrlport_req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]            pending,
    input  logic [idx_width(NUM_PORTS)-1:0] last_grant,
    output logic                            valid,
    output logic [idx_width(NUM_PORTS)-1:0] grant
);
    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam logic [IDX_W:0] PORTS_W = (IDX_W + 1)'(NUM_PORTS);

    logic [IDX_W:0] cand;

    // One spare bit lets last_grant + offset wrap with a single subtract.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        cand  = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = {1'b0, last_grant} + (IDX_W + 1)'(off);
            if (cand >= PORTS_W) begin
                cand = cand - PORTS_W;
            end
            if (!valid && pending[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                grant = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ctrlport_req_arbiter.sv
// rtl/ctrlport_req_arbiter.sv - shares one ControlPort master between single-request masters
module ctrlport_req_arbiter
    import ctrlport_req_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      ctrlport_clk,
    input  logic                      ctrlport_rst_n,
    input  logic [NUM_PORTS-1:0]      s_ctrlport_req_wr,
    input  logic [NUM_PORTS-1:0]      s_ctrlport_req_rd,
    input  logic [20*NUM_PORTS-1:0]   s_ctrlport_req_addr,
    input  logic [32*NUM_PORTS-1:0]   s_ctrlport_req_data,
    input  logic [4*NUM_PORTS-1:0]    s_ctrlport_req_byte_en,
    output logic [NUM_PORTS-1:0]      s_ctrlport_resp_ack,
    output logic [2*NUM_PORTS-1:0]    s_ctrlport_resp_status,
    output logic [32*NUM_PORTS-1:0]   s_ctrlport_resp_data,
    output logic                      m_ctrlport_req_wr,
    output logic                      m_ctrlport_req_rd,
    output logic [19:0]               m_ctrlport_req_addr,
    output logic [31:0]               m_ctrlport_req_data,
    output logic [3:0]                m_ctrlport_req_byte_en,
    input  logic                      m_ctrlport_resp_ack,
    input  logic [1:0]                m_ctrlport_resp_status,
    input  logic [31:0]               m_ctrlport_resp_data,
    output logic [NUM_PORTS-1:0]      drop_pulse,
    output logic                      timeout_pulse
);
    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t           state;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] slot_wr;
    logic [19:0]          slot_addr    [NUM_PORTS];
    logic [31:0]          slot_data    [NUM_PORTS];
    logic [3:0]           slot_byte_en [NUM_PORTS];
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     rr_grant;
    logic                 rr_valid;
    logic [CNT_W-1:0]     wait_cnt;

    ctrlport_rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
        .pending    (pending),
        .last_grant (last_grant),
        .valid      (rr_valid),
        .grant      (rr_grant)
    );

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            state                  <= ST_IDLE;
            pending                <= '0;
            slot_wr                <= '0;
            last_grant             <= IDX_W'(NUM_PORTS - 1);
            wait_cnt               <= '0;
            s_ctrlport_resp_ack    <= '0;
            s_ctrlport_resp_status <= '0;
            s_ctrlport_resp_data   <= '0;
            m_ctrlport_req_wr      <= 1'b0;
            m_ctrlport_req_rd      <= 1'b0;
            m_ctrlport_req_addr    <= '0;
            m_ctrlport_req_data    <= '0;
            m_ctrlport_req_byte_en <= '0;
            drop_pulse             <= '0;
            timeout_pulse          <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot_addr[i]    <= '0;
                slot_data[i]    <= '0;
                slot_byte_en[i] <= '0;
            end
        end else begin
            s_ctrlport_resp_ack    <= '0;
            s_ctrlport_resp_status <= '0;
            s_ctrlport_resp_data   <= '0;
            m_ctrlport_req_wr      <= 1'b0;
            m_ctrlport_req_rd      <= 1'b0;
            drop_pulse             <= '0;
            timeout_pulse          <= 1'b0;

            // A write wins when a port raises wr and rd together.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (s_ctrlport_req_wr[i] || s_ctrlport_req_rd[i]) begin
                    if (pending[i]) begin
                        drop_pulse[i] <= 1'b1;
                    end else begin
                        pending[i]      <= 1'b1;
                        slot_wr[i]      <= s_ctrlport_req_wr[i];
                        slot_addr[i]    <= s_ctrlport_req_addr[20*i +: 20];
                        slot_data[i]    <= s_ctrlport_req_data[32*i +: 32];
                        slot_byte_en[i] <= s_ctrlport_req_byte_en[4*i +: 4];
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        last_grant             <= rr_grant;
                        m_ctrlport_req_wr      <= slot_wr[rr_grant];
                        m_ctrlport_req_rd      <= ~slot_wr[rr_grant];
                        m_ctrlport_req_addr    <= slot_addr[rr_grant];
                        m_ctrlport_req_data    <= slot_data[rr_grant];
                        m_ctrlport_req_byte_en <= slot_byte_en[rr_grant];
                        state                  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack landing on the expiry cycle still counts as a real response.
                    if (m_ctrlport_resp_ack) begin
                        s_ctrlport_resp_ack[last_grant]             <= 1'b1;
                        s_ctrlport_resp_status[2*last_grant +: 2]   <= m_ctrlport_resp_status;
                        s_ctrlport_resp_data[32*last_grant +: 32]   <= m_ctrlport_resp_data;
                        pending[last_grant]                         <= 1'b0;
                        state                                       <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        s_ctrlport_resp_ack[last_grant]             <= 1'b1;
                        s_ctrlport_resp_status[2*last_grant +: 2]   <= CTRL_STS_CMDERR;
                        timeout_pulse                               <= 1'b1;
                        pending[last_grant]                         <= 1'b0;
                        state                                       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrlport_req_arbiter.sv
// tb/tb_ctrlport_req_arbiter.sv - self-checking bench for ctrlport_req_arbiter
module tb_ctrlport_req_arbiter;
    localparam int P = 2;
    localparam int T = 16;
    localparam logic [1:0] STS_OKAY   = 2'b00;
    localparam logic [1:0] STS_CMDERR = 2'b01;

    logic            ctrlport_clk = 1'b0;
    logic            ctrlport_rst_n = 1'b0;
    logic [P-1:0]    s_ctrlport_req_wr = '0;
    logic [P-1:0]    s_ctrlport_req_rd = '0;
    logic [20*P-1:0] s_ctrlport_req_addr = '0;
    logic [32*P-1:0] s_ctrlport_req_data = '0;
    logic [4*P-1:0]  s_ctrlport_req_byte_en = '0;
    logic [P-1:0]    s_ctrlport_resp_ack;
    logic [2*P-1:0]  s_ctrlport_resp_status;
    logic [32*P-1:0] s_ctrlport_resp_data;
    logic            m_ctrlport_req_wr;
    logic            m_ctrlport_req_rd;
    logic [19:0]     m_ctrlport_req_addr;
    logic [31:0]     m_ctrlport_req_data;
    logic [3:0]      m_ctrlport_req_byte_en;
    logic            m_ctrlport_resp_ack = 1'b0;
    logic [1:0]      m_ctrlport_resp_status = '0;
    logic [31:0]     m_ctrlport_resp_data = '0;
    logic [P-1:0]    drop_pulse;
    logic            timeout_pulse;

    int checks = 0;
    int errors = 0;

    always #5 ctrlport_clk = ~ctrlport_clk;

    ctrlport_req_arbiter #(.NUM_PORTS(P), .TIMEOUT_CYCLES(T)) dut (
        .ctrlport_clk           (ctrlport_clk),
        .ctrlport_rst_n         (ctrlport_rst_n),
        .s_ctrlport_req_wr      (s_ctrlport_req_wr),
        .s_ctrlport_req_rd      (s_ctrlport_req_rd),
        .s_ctrlport_req_addr    (s_ctrlport_req_addr),
        .s_ctrlport_req_data    (s_ctrlport_req_data),
        .s_ctrlport_req_byte_en (s_ctrlport_req_byte_en),
        .s_ctrlport_resp_ack    (s_ctrlport_resp_ack),
        .s_ctrlport_resp_status (s_ctrlport_resp_status),
        .s_ctrlport_resp_data   (s_ctrlport_resp_data),
        .m_ctrlport_req_wr      (m_ctrlport_req_wr),
        .m_ctrlport_req_rd      (m_ctrlport_req_rd),
        .m_ctrlport_req_addr    (m_ctrlport_req_addr),
        .m_ctrlport_req_data    (m_ctrlport_req_data),
        .m_ctrlport_req_byte_en (m_ctrlport_req_byte_en),
        .m_ctrlport_resp_ack    (m_ctrlport_resp_ack),
        .m_ctrlport_resp_status (m_ctrlport_resp_status),
        .m_ctrlport_resp_data   (m_ctrlport_resp_data),
        .drop_pulse             (drop_pulse),
        .timeout_pulse          (timeout_pulse)
    );

    function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Transaction-timeline model: slots, an owner and the cycle its request went out.
    logic        mp_pend [P];
    logic        mp_wr   [P];
    logic [19:0] mp_addr [P];
    logic [31:0] mp_data [P];
    logic [3:0]  mp_be   [P];
    int owner, issue_cyc, mcyc, last_g;

    logic [P-1:0]    e_s_ack;
    logic [2*P-1:0]  e_s_status;
    logic [32*P-1:0] e_s_data;
    logic            e_m_wr, e_m_rd, e_to;
    logic [19:0]     e_m_addr;
    logic [31:0]     e_m_data;
    logic [3:0]      e_m_be;
    logic [P-1:0]    e_drop;

    task automatic model_reset();
        owner = -1; issue_cyc = 0; mcyc = 0; last_g = P - 1;
        for (int p = 0; p < P; p++) begin
            mp_pend[p] = 0; mp_wr[p] = 0; mp_addr[p] = '0; mp_data[p] = '0; mp_be[p] = '0;
        end
        e_s_ack = '0; e_s_status = '0; e_s_data = '0; e_m_wr = 0; e_m_rd = 0; e_to = 0;
        e_m_addr = '0; e_m_data = '0; e_m_be = '0; e_drop = '0;
    endtask

    task automatic model_step();
        logic old_pend [P];
        int resp_o;
        int p;
        old_pend = mp_pend;
        resp_o = -1;
        e_s_ack = '0; e_s_status = '0; e_s_data = '0; e_drop = '0; e_to = 0; e_m_wr = 0; e_m_rd = 0;
        if (owner < 0) begin
            for (int off = 1; off <= P; off++) begin
                p = (last_g + off) % P;
                if (old_pend[p]) begin
                    owner = p; last_g = p; issue_cyc = mcyc + 1;
                    e_m_wr = mp_wr[p]; e_m_rd = !mp_wr[p];
                    e_m_addr = mp_addr[p]; e_m_data = mp_data[p]; e_m_be = mp_be[p];
                    break;
                end
            end
        end else if (mcyc > issue_cyc) begin
            if (m_ctrlport_resp_ack) begin
                resp_o = owner;
                e_s_status[2*owner +: 2] = m_ctrlport_resp_status;
                e_s_data[32*owner +: 32] = m_ctrlport_resp_data;
            end else if (mcyc - issue_cyc == T) begin
                resp_o = owner;
                e_s_status[2*owner +: 2] = STS_CMDERR;
                e_to = 1;
            end
            if (resp_o >= 0) begin
                e_s_ack[resp_o] = 1'b1;
                owner = -1;
            end
        end
        for (int q = 0; q < P; q++) begin
            if (s_ctrlport_req_wr[q] || s_ctrlport_req_rd[q]) begin
                if (old_pend[q]) begin
                    e_drop[q] = 1'b1;
                end else begin
                    mp_pend[q] = 1; mp_wr[q] = s_ctrlport_req_wr[q];
                    mp_addr[q] = s_ctrlport_req_addr[20*q +: 20];
                    mp_data[q] = s_ctrlport_req_data[32*q +: 32];
                    mp_be[q]   = s_ctrlport_req_byte_en[4*q +: 4];
                end
            end
        end
        if (resp_o >= 0) mp_pend[resp_o] = 0;
        mcyc++;
    endtask

    always @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) model_reset();
        else model_step();
    end

    always @(negedge ctrlport_clk) begin
        chk("cmp_s_ack",    64'(s_ctrlport_resp_ack),    64'(e_s_ack));
        chk("cmp_s_status", 64'(s_ctrlport_resp_status), 64'(e_s_status));
        chk("cmp_s_data",   64'(s_ctrlport_resp_data),   64'(e_s_data));
        chk("cmp_m_wr",     64'(m_ctrlport_req_wr),      64'(e_m_wr));
        chk("cmp_m_rd",     64'(m_ctrlport_req_rd),      64'(e_m_rd));
        chk("cmp_m_addr",   64'(m_ctrlport_req_addr),    64'(e_m_addr));
        chk("cmp_m_data",   64'(m_ctrlport_req_data),    64'(e_m_data));
        chk("cmp_m_be",     64'(m_ctrlport_req_byte_en), 64'(e_m_be));
        chk("cmp_drop",     64'(drop_pulse),             64'(e_drop));
        chk("cmp_timeout",  64'(timeout_pulse),          64'(e_to));
    end

    task automatic next_cycle();
        @(negedge ctrlport_clk);
        #1;
        s_ctrlport_req_wr = '0;
        s_ctrlport_req_rd = '0;
        m_ctrlport_resp_ack = 1'b0;
    endtask

    task automatic req(input int p, input bit wr, input logic [19:0] a, input logic [31:0] d);
        if (wr) s_ctrlport_req_wr[p] = 1'b1;
        else    s_ctrlport_req_rd[p] = 1'b1;
        s_ctrlport_req_addr[20*p +: 20]  = a;
        s_ctrlport_req_data[32*p +: 32]  = d;
        s_ctrlport_req_byte_en[4*p +: 4] = 4'hF;
    endtask

    task automatic ack_now(input logic [1:0] sts, input logic [31:0] d);
        m_ctrlport_resp_ack = 1'b1;
        m_ctrlport_resp_status = sts;
        m_ctrlport_resp_data = d;
    endtask

    task automatic wait_issue(output logic [19:0] a);
        for (int k = 0; k < 40; k++) begin
            if (m_ctrlport_req_wr || m_ctrlport_req_rd) break;
            next_cycle();
        end
        chk("issue_seen", 64'(m_ctrlport_req_wr | m_ctrlport_req_rd), 64'(1));
        a = m_ctrlport_req_addr;
    endtask

    task automatic do_reset();
        next_cycle();
        ctrlport_rst_n = 1'b0;
        next_cycle();
        ctrlport_rst_n = 1'b1;
    endtask

    task automatic issue_ack(input logic [1:0] sts, input logic [31:0] d, output logic [19:0] a);
        wait_issue(a);
        next_cycle();
        ack_now(sts, d);
        next_cycle();
    endtask

    initial begin
        logic [19:0] a;
        repeat (3) @(negedge ctrlport_clk);
        #1;
        ctrlport_rst_n = 1'b1;
        chk("rst_m_addr", 64'(m_ctrlport_req_addr), 64'(0));
        chk("rst_s_ack",  64'(s_ctrlport_resp_ack), 64'(0));

        // Single write from port 0
        next_cycle();
        req(0, 1, 20'h1_0040, 32'h3);
        next_cycle();
        chk("t1_no_issue_k1", 64'(m_ctrlport_req_wr), 64'(0));
        next_cycle();
        chk("t1_wr_k2", 64'(m_ctrlport_req_wr), 64'(1));
        chk("t1_addr",  64'(m_ctrlport_req_addr), 64'(20'h1_0040));
        chk("t1_data",  64'(m_ctrlport_req_data), 64'(32'h3));
        next_cycle();
        chk("t1_wr_one_cycle", 64'(m_ctrlport_req_wr), 64'(0));
        next_cycle();
        next_cycle();
        ack_now(STS_OKAY, 32'h0);
        next_cycle();
        chk("t1_s_ack",    64'(s_ctrlport_resp_ack), 64'(2'b01));
        chk("t1_s_status", 64'(s_ctrlport_resp_status), 64'(0));

        // Contention after reset: 0 then 1; then 0 alone; then both again gives 1 then 0
        do_reset();
        next_cycle();
        req(0, 1, 20'h00100, 32'hA0);
        req(1, 1, 20'h00200, 32'hA1);
        next_cycle();
        issue_ack(STS_OKAY, 32'h0, a);
        chk("t2_first",  64'(a), 64'(20'h00100));
        chk("t2_ack0",   64'(s_ctrlport_resp_ack), 64'(2'b01));
        issue_ack(STS_OKAY, 32'h0, a);
        chk("t2_second", 64'(a), 64'(20'h00200));
        req(0, 1, 20'h00300, 32'hA2);
        next_cycle();
        issue_ack(STS_OKAY, 32'h0, a);
        chk("t2_alone",  64'(a), 64'(20'h00300));
        req(0, 1, 20'h00400, 32'hA3);
        req(1, 1, 20'h00500, 32'hA4);
        next_cycle();
        issue_ack(STS_OKAY, 32'h0, a);
        chk("t2_rr_first",  64'(a), 64'(20'h00500));
        issue_ack(STS_OKAY, 32'h0, a);
        chk("t2_rr_second", 64'(a), 64'(20'h00400));

        // Drop: second request on a pending slot is discarded
        req(1, 1, 20'h1_2345, 32'h11);
        next_cycle();
        req(1, 1, 20'h0_0BAD, 32'h22);
        next_cycle();
        chk("t3_drop",   64'(drop_pulse), 64'(2'b10));
        chk("t3_addr",   64'(m_ctrlport_req_addr), 64'(20'h1_2345));
        chk("t3_data",   64'(m_ctrlport_req_data), 64'(32'h11));
        next_cycle();
        ack_now(STS_OKAY, 32'h0);
        next_cycle();
        chk("t3_ack", 64'(s_ctrlport_resp_ack), 64'(2'b10));

        // Timeout: no downstream ack
        req(0, 1, 20'h00777, 32'h5);
        next_cycle();
        wait_issue(a);
        for (int i = 1; i <= T; i++) next_cycle();
        chk("t4_no_early_ack", 64'(s_ctrlport_resp_ack), 64'(0));
        next_cycle();
        chk("t4_ack",     64'(s_ctrlport_resp_ack), 64'(2'b01));
        chk("t4_status",  64'(s_ctrlport_resp_status), 64'(4'b0001));
        chk("t4_data",    64'(s_ctrlport_resp_data), 64'(0));
        chk("t4_timeout", 64'(timeout_pulse), 64'(1));
        repeat (5) next_cycle();
        ack_now(STS_OKAY, 32'h5555);
        next_cycle();
        chk("t4_late_ack", 64'(s_ctrlport_resp_ack), 64'(0));

        // Read path on port 1
        req(1, 0, 20'h00ABC, 32'h0);
        next_cycle();
        wait_issue(a);
        chk("t5_rd", 64'({m_ctrlport_req_rd, m_ctrlport_req_wr}), 64'(2'b10));
        next_cycle();
        ack_now(STS_OKAY, 32'hDEADBEEF);
        next_cycle();
        chk("t5_ack",    64'(s_ctrlport_resp_ack), 64'(2'b10));
        chk("t5_data",   64'(s_ctrlport_resp_data), 64'hDEADBEEF_00000000);
        chk("t5_status", 64'(s_ctrlport_resp_status), 64'(0));

        // Reset while waiting for a response
        req(0, 1, 20'h0F0F0, 32'h77);
        next_cycle();
        wait_issue(a);
        next_cycle();
        ctrlport_rst_n = 1'b0;
        #1;
        chk("t6_async_zero", 64'({m_ctrlport_req_addr, m_ctrlport_req_data[7:0], s_ctrlport_resp_ack,
                                  m_ctrlport_req_wr, m_ctrlport_req_byte_en}), 64'(0));
        next_cycle();
        ctrlport_rst_n = 1'b1;
        next_cycle();
        ack_now(STS_OKAY, 32'h1234);
        next_cycle();
        chk("t6_no_resp", 64'(s_ctrlport_resp_ack), 64'(0));
        req(1, 1, 20'h0A0A0, 32'h99);
        next_cycle();
        issue_ack(STS_OKAY, 32'h0, a);
        chk("t6_fresh_addr", 64'(a), 64'(20'h0A0A0));
        chk("t6_fresh_ack",  64'(s_ctrlport_resp_ack), 64'(2'b10));

        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
